nes_controller_responder: RTL and testbench



---
 rtl/nes_controller_responder.sv | 120 ++++++++++++
 tb/tb_nes_controller_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_responder.sv
// ============================================================================
//  Module   : nes_controller_responder
//  Brief    : Device side of the NES gamepad link; latches buttons, shifts them
//             out active-low on host clock rising edges.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_controller_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_BITS    = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_BITS-1:0]            pressed,
   input  logic                           nes_latch,
   input  logic                           nes_clock,
   output logic                           nes_data,
   output logic                           frame_done,
   output logic [$clog2(NUM_BITS+1)-1:0]  bit_count
);

   localparam int CW = $clog2(NUM_BITS+1);
   localparam logic [CW-1:0] c_LAST = CW'(NUM_BITS-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_latch_sync;
   logic [SYNC_STAGES-1:0] r_clock_sync;
   logic                   r_clock_q;
   state_t                 r_state;
   logic [NUM_BITS-1:0]    r_shift;
   logic [CW-1:0]          r_count;
   logic                   r_nes_data;
   logic                   r_frame_done;

   logic                   w_latch_s;
   logic                   w_clock_s;
   logic                   w_clk_rise;
   state_t                 w_state_next;
   logic [NUM_BITS-1:0]    w_shift_next;
   logic [CW-1:0]          w_count_next;
   logic                   w_done_next;
   logic                   w_data_next;

   assign w_latch_s  = r_latch_sync[SYNC_STAGES-1];
   assign w_clock_s  = r_clock_sync[SYNC_STAGES-1];
   assign w_clk_rise = w_clock_s & ~r_clock_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_latch_sync <= '0;
         r_clock_sync <= '0;
         r_clock_q    <= 1'b0;
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_count      <= '0;
         r_nes_data   <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], nes_latch};
         r_clock_sync <= {r_clock_sync[SYNC_STAGES-2:0], nes_clock};
         r_clock_q    <= w_clock_s;
         r_state      <= w_state_next;
         r_shift      <= w_shift_next;
         r_count      <= w_count_next;
         r_nes_data   <= w_data_next;
         r_frame_done <= w_done_next;
      end
   end

   // A high latch overrides everything, including a coincident clock edge,
   // and keeps resampling the buttons so the last sample before it falls wins.
   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_count_next = r_count;
      w_done_next  = 1'b0;
      if (w_latch_s) begin
         w_state_next = S_LOAD;
         w_shift_next = pressed;
         w_count_next = '0;
      end else begin
         case (r_state)
            S_IDLE: w_state_next = S_IDLE;
            S_LOAD: w_state_next = S_SHIFT;
            S_SHIFT: begin
               if (w_clk_rise) begin
                  w_shift_next = r_shift << 1;
                  w_count_next = r_count + 1'b1;
                  if (r_count == c_LAST) begin
                     w_state_next = S_DONE;
                     w_done_next  = 1'b1;
                  end
               end
            end
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
         endcase
      end
      // Output register tracks the next state so data appears with the shift.
      if ((w_state_next == S_LOAD) || (w_state_next == S_SHIFT)) begin
         w_data_next = ~w_shift_next[NUM_BITS-1];
      end else begin
         w_data_next = 1'b1;
      end
   end

   assign nes_data   = r_nes_data;
   assign frame_done = r_frame_done;
   assign bit_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_nes_controller_responder.sv
// ============================================================================
//  Module   : tb_nes_controller_responder
//  Brief    : Self-checking bench driving an emulated NES host against the
//             responder and comparing every bit with the expected frame.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nes_controller_responder;

   logic       clk;
   logic       reset;
   logic [7:0] pressed;
   logic       nes_latch;
   logic       nes_clock;
   logic       nes_data;
   logic       frame_done;
   logic [3:0] bit_count;

   int tests_run;
   int tests_failed;
   int fd_count;

   nes_controller_responder #(
      .SYNC_STAGES (2),
      .NUM_BITS    (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pressed    (pressed),
      .nes_latch  (nes_latch),
      .nes_clock  (nes_clock),
      .nes_data   (nes_data),
      .frame_done (frame_done),
      .bit_count  (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_count++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Host half period in clk cycles, always well above the sync latency.
   function automatic int half();
      return 8 + int'($urandom_range(0, 3));
   endfunction

   task automatic async_gap();
      @(posedge clk);
      #($urandom_range(1, 9));
   endtask

   task automatic host_latch();
      async_gap();
      nes_latch = 1'b1;
      repeat (half()) @(posedge clk);
      #($urandom_range(1, 9));
      nes_latch = 1'b0;
      repeat (half()) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic host_pulse();
      async_gap();
      nes_clock = 1'b1;
      repeat (half()) @(posedge clk);
      #($urandom_range(1, 9));
      nes_clock = 1'b0;
      repeat (half()) @(posedge clk);
      @(negedge clk);
   endtask

   // Frame model: after k shifts the line carries the k-th button in
   // A..Right order, inverted; past the last button the line idles high.
   task automatic run_frame(input logic [7:0] p, input int npulses);
      int         fd0;
      logic [7:0] snap;
      fd0     = fd_count;
      snap    = p;
      pressed = p;
      host_latch();
      pressed = 8'($urandom);
      check("first_bit", {31'd0, nes_data}, {31'd0, ~snap[7]});
      check("count_after_latch", {28'd0, bit_count}, 32'd0);
      for (int k = 1; k <= npulses; k++) begin
         host_pulse();
         if (k < 8) check("data_bit", {31'd0, nes_data}, {31'd0, ~snap[7-k]});
         else       check("data_idle", {31'd0, nes_data}, 32'd1);
         check("bit_count", {28'd0, bit_count}, (k < 8) ? k : 8);
      end
      check("frame_done_pulses", fd_count - fd0, (npulses >= 8) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int fd0;
      tests_run    = 0;
      tests_failed = 0;
      fd_count     = 0;
      reset        = 1'b1;
      pressed      = 8'h00;
      nes_latch    = 1'b0;
      nes_clock    = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_data", {31'd0, nes_data}, 32'd1);
      check("reset_done", {31'd0, frame_done}, 32'd0);
      check("reset_count", {28'd0, bit_count}, 32'd0);

      // Clock pulses with no latch: nothing moves.
      pressed = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         host_pulse();
         check("nolatch_data", {31'd0, nes_data}, 32'd1);
         check("nolatch_count", {28'd0, bit_count}, 32'd0);
      end
      check("nolatch_fd", fd_count, 32'd0);

      // Basic frame plus 12 surplus pulses: 0,1,1,1,1,1,1,0 then idle high.
      run_frame(8'h81, 20);

      // Abandoned frame after 3 shifts, then a fresh frame with only B.
      fd0 = fd_count;
      run_frame(8'hC3, 3);
      run_frame(8'h40, 8);
      check("abort_no_extra_fd", fd_count - fd0, 32'd1);

      // Latch and clock rising together: latch wins, nothing is shifted.
      pressed = 8'h3C;
      host_latch();
      host_pulse();
      host_pulse();
      pressed = 8'h96;
      async_gap();
      nes_latch = 1'b1;
      nes_clock = 1'b1;
      repeat (10) @(posedge clk);
      #3 nes_latch = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("coincident_data", {31'd0, nes_data}, {31'd0, ~pressed[7]});
      check("coincident_count", {28'd0, bit_count}, 32'd0);
      nes_clock = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("coincident_idle_clock", {28'd0, bit_count}, 32'd0);
      host_pulse();
      check("coincident_next_bit", {31'd0, nes_data}, {31'd0, ~pressed[6]});
      check("coincident_next_count", {28'd0, bit_count}, 32'd1);

      // Reset after bit 4: line goes idle and stays there until a latch.
      run_frame(8'h00, 4);
      async_gap();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_data", {31'd0, nes_data}, 32'd1);
      check("midreset_count", {28'd0, bit_count}, 32'd0);
      fd0 = fd_count;
      for (int i = 0; i < 5; i++) host_pulse();
      check("postreset_data", {31'd0, nes_data}, 32'd1);
      check("postreset_count", {28'd0, bit_count}, 32'd0);
      check("postreset_fd", fd_count - fd0, 32'd0);
      run_frame(8'hA5, 8);

      // Random buttons with random host phase and jitter.
      for (int f = 0; f < 200; f++) begin
         run_frame(8'($urandom), 8 + int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule

`default_nettype wire
